adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  NREQ  per-requester operation request.
REQ-005 Port: req_ready  output  NREQ  per-requester grant, one-hot or zero.
REQ-006 Port: req_a  input  8*NREQ  operand A; requester i at bits [8i+7:8i].
REQ-007 Port: req_b  input  8*NREQ  operand B; same packing as req_a.
REQ-008 Port: rsp_valid  output  NREQ  per-requester result held.
REQ-009 Port: rsp_ready  input  NREQ  per-requester result accept.
REQ-010 Port: rsp_sum  output  9*NREQ  result; requester i at bits [9i+8:9i].
REQ-011 Port: add_a, add_b  output  8 each  operands to the shared adder.
REQ-012 Port: add_valid  output  1  operation issue strobe to the adder.
REQ-013 Port: add_sum  input  9  adder result.
REQ-014 Port: add_out_valid  input  1  adder result strobe, exactly 1 cycle after add_valid.
REQ-015 Port: op_count  output  16  count of results delivered to requesters.
REQ-016 Port: err  output  1  sticky protocol-error flag.

Function
REQ-017 Requester i SHALL be eligible in a cycle iff req_valid[i]=1, (rsp_valid[i]=0 or rsp_ready[i]=1), and no operation for i is in flight.
REQ-018 Arbitration SHALL be round-robin: search eligible requesters starting at pointer ptr, ascending, wrapping NREQ-1 -> 0; first eligible wins.
REQ-019 On a grant to i, ptr SHALL become (i+1) mod NREQ next cycle; with no grant, ptr SHALL hold.
REQ-020 req_ready SHALL be combinational, at most one bit set, set only for the winner; transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-021 add_valid SHALL equal 1 exactly when a grant occurs; add_a/add_b SHALL carry the winner's operands, and 0 when add_valid=0.
REQ-022 In-flight tracker: inflight_q <= grant_any, id_q <= winner index, every cycle; at most one operation in flight; one issue per cycle sustained across different requesters.
REQ-023 On add_out_valid=1 with inflight_q=1: rsp_sum[id_q] <= add_sum (full 9 bits, carry in bit 8), rsp_valid[id_q] <= 1.
REQ-024 rsp_valid[i] and rsp_sum[i] SHALL hold until rsp_ready[i]=1; then rsp_valid[i] clears next cycle unless set by REQ-023 in the same cycle (set wins).
REQ-025 A single requester SHALL achieve at most one operation every 2 cycles; back-to-back grants to the same requester are forbidden by REQ-017.
REQ-026 op_count SHALL increment by 1 per rsp_valid/rsp_ready handshake, by up to NREQ in one cycle if several occur, wrapping 0xFFFF -> 0x0000.
REQ-027 err SHALL set and stay set if add_out_valid=1 with inflight_q=0, or add_out_valid=0 with inflight_q=1; the offending strobe is ignored and no response is written.
REQ-028 Zero operands, 0xFF+0xFF=0x1FE, and all req_valid deasserted SHALL need no special handling.

Reset
REQ-029 With rst=1 at a clock edge: ptr=0, inflight_q=0, id_q=0, rsp_valid=0, rsp_sum=0, op_count=0, err=0.
REQ-030 While rst=1: req_ready=0, add_valid=0, add_a=add_b=0; a result arriving in the cycle after reset deassertion for a pre-reset issue SHALL be treated per REQ-027.
REQ-031 Reset asserted mid-operation SHALL discard in-flight and held results; no response delivered for them.

Verification
REQ-032 Single request: req 0 a=0x12 b=0x34 -> req_ready[0] same cycle, add_valid=1, rsp_valid[0]=1 with rsp_sum[0]=0x046 two edges later; op_count=1 after accept.
REQ-033 All four valid continuously, rsp_ready=all 1 -> grants 0,1,2,3,0,... one per cycle; no requester granted in consecutive cycles.
REQ-034 Carry: a=0xFF b=0xFF -> rsp_sum=0x1FE; a=0x80 b=0x80 -> 0x100.
REQ-035 Backpressure: rsp_ready[2]=0 with rsp_valid[2]=1, req_valid[2]=1 -> req 2 never granted, others rotate; on rsp_ready[2]=1 req 2 granted that cycle.
REQ-036 Protocol error: add_out_valid pulse with no issue -> err=1 permanently, rsp_valid unchanged; rst=1 -> err=0.
REQ-037 Reset mid-flight: grant at cycle t, rst=1 at t+1 -> rsp_valid stays 0, op_count=0.

Source files
------------

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Shares one external 1-cycle-latency 8-bit adder between NREQ requesters.
// A round-robin arbiter picks at most one eligible requester per cycle and
// issues its operands to the adder. The result returns one cycle later and is
// held per requester until that requester accepts it.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req_valid      [NREQ]    per-requester operation request
//   req_ready      [NREQ]    per-requester grant (one-hot or zero, combinational)
//   req_a, req_b   [8*NREQ]  operands, requester i at [8i+7:8i]
//   rsp_valid      [NREQ]    per-requester result held
//   rsp_ready      [NREQ]    per-requester result accept
//   rsp_sum        [9*NREQ]  results, requester i at [9i+8:9i]
//   add_a, add_b   [8]       operands to the shared adder (0 when idle)
//   add_valid                issue strobe to the adder
//   add_sum        [9]       adder result
//   add_out_valid            adder result strobe (1 cycle after add_valid)
//   op_count       [16]      number of results delivered, wrapping
//   err                      sticky protocol-error flag
// ---------------------------------------------------------------------------
module adder_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [9*NREQ-1:0]    rsp_sum,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    output logic                 add_valid,
    input  logic [8:0]           add_sum,
    input  logic                 add_out_valid,
    output logic [15:0]          op_count,
    output logic                 err
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]  ptr_reg, ptr_next;
    logic           inflight_reg;
    logic [IW-1:0]  id_reg;
    logic [15:0]    op_count_reg;
    logic           err_reg;

    logic [NREQ-1:0] eligible;
    logic [7:0]      a_arr [NREQ];
    logic [7:0]      b_arr [NREQ];
    logic            grant_any;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic [15:0]     accept_cnt;
    logic            deliver;

    // A returning result is only trusted when it matches an issued operation;
    // any mismatch in either direction is a protocol error.
    assign deliver = add_out_valid & inflight_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic       valid_bit_reg;
            logic [8:0] sum_reg;

            assign a_arr[gi] = req_a[8*gi +: 8];
            assign b_arr[gi] = req_b[8*gi +: 8];

            // Not eligible while its own operation is in flight, nor while an
            // unaccepted result would be overwritten. Reset blocks all grants.
            assign eligible[gi] = !rst && req_valid[gi]
                                  && (!valid_bit_reg || rsp_ready[gi])
                                  && !(inflight_reg && (id_reg == IW'(gi)));

            assign req_ready[gi] = grant_any && (winner == IW'(gi));

            // A newly delivered result takes priority over a same-cycle accept.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_bit_reg <= 1'b0;
                    sum_reg       <= '0;
                end else if (deliver && (id_reg == IW'(gi))) begin
                    valid_bit_reg <= 1'b1;
                    sum_reg       <= add_sum;
                end else if (rsp_ready[gi]) begin
                    valid_bit_reg <= 1'b0;
                end
            end

            assign rsp_valid[gi]       = valid_bit_reg;
            assign rsp_sum[9*gi +: 9]  = sum_reg;
        end
    endgenerate

    // Round-robin search starting at ptr_reg, wrapping NREQ-1 -> 0.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        winner    = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Number of response handshakes this cycle (several may coincide).
    always_comb begin
        accept_cnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            accept_cnt = accept_cnt + 16'(rsp_valid[k] & rsp_ready[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            inflight_reg <= 1'b0;
            id_reg       <= '0;
            op_count_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            inflight_reg <= grant_any;
            id_reg       <= winner;
            op_count_reg <= op_count_reg + accept_cnt;
            err_reg      <= err_reg | (add_out_valid != inflight_reg);
        end
    end

    assign add_valid = grant_any;
    assign add_a     = grant_any ? a_arr[winner] : 8'h00;
    assign add_b     = grant_any ? b_arr[winner] : 8'h00;
    assign op_count  = op_count_reg;
    assign err       = err_reg;

endmodule
